// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control sequencer for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects and write strobes, selects the immediate-extension mode,
// handshakes with a variable-latency memory port and counts retired
// instructions.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   opcode, funct        IR[31:26] / IR[5:0], stable after FETCH
//   zero                 ALU zero flag (beq decision)
//   mem_ready            memory completes the current access this cycle
//   mem_re, mem_we       memory read / write strobes
//   iord                 memory address select (0 PC, 1 ALUOut)
//   ir_we, pc_we         IR/MDR load, PC write enable
//   pc_src               PC source (00 ALU, 01 ALUOut, 10 jump target)
//   alu_src_a/alu_src_b  ALU operand selects
//   ext_op               immediate extension (00 sign, 01 zero, 10 upper)
//   alu_op               0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 PASS_B
//   reg_we, reg_dst, mem_to_reg  register-file write controls
//   illegal              one-cycle pulse on an unsupported instruction
//   retired              completed-instruction count (wraps)
//   state                current state, for debug
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ext_op,
  output logic [2:0]       alu_op,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IDLE   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_PASS = 3'd5;

  state_t cur, nxt;
  logic   retire;

  // Instruction classification
  logic       is_r, is_iarith, is_lw, is_sw, is_beq, is_j, legal;
  logic [2:0] r_alu, i_alu;
  logic [1:0] i_ext;

  always_comb begin
    is_r      = 1'b0;
    is_iarith = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_j      = 1'b0;
    r_alu     = ALU_ADD;
    i_alu     = ALU_ADD;
    i_ext     = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        is_r = 1'b1;
        case (funct)
          6'h21:   r_alu = ALU_ADD;
          6'h23:   r_alu = ALU_SUB;
          6'h24:   r_alu = ALU_AND;
          6'h25:   r_alu = ALU_OR;
          6'h2A:   r_alu = ALU_SLT;
          default: is_r  = 1'b0;
        endcase
      end
      OP_ADDIU: begin is_iarith = 1'b1; i_alu = ALU_ADD;  i_ext = 2'b00; end
      OP_ANDI:  begin is_iarith = 1'b1; i_alu = ALU_AND;  i_ext = 2'b01; end
      OP_ORI:   begin is_iarith = 1'b1; i_alu = ALU_OR;   i_ext = 2'b01; end
      OP_LUI:   begin is_iarith = 1'b1; i_alu = ALU_PASS; i_ext = 2'b10; end
      OP_LW:    is_lw  = 1'b1;
      OP_SW:    is_sw  = 1'b1;
      OP_BEQ:   is_beq = 1'b1;
      OP_J:     is_j   = 1'b1;
      default:  ;
    endcase
    legal = is_r | is_iarith | is_lw | is_sw | is_beq | is_j;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= S_IDLE;
      retired <= '0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + 1'b1;
    end
  end

  always_comb begin
    nxt        = cur;
    retire     = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_IDLE: nxt = S_FETCH;
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALUOut captures PC + (sext(imm) << 2) for a possible branch
        alu_src_b = 2'b11;
        if (is_j) begin
          pc_we  = 1'b1;
          pc_src = 2'b10;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (!legal) begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        nxt       = S_FETCH;
        if (is_r) begin
          alu_op = r_alu;
          nxt    = S_WB;
        end else if (is_iarith) begin
          alu_src_b = 2'b10;
          ext_op    = i_ext;
          alu_op    = i_alu;
          nxt       = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 2'b10;
          nxt       = S_MEM;
        end else if (is_beq) begin
          alu_op = ALU_SUB;
          pc_src = 2'b01;
          pc_we  = zero;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (is_lw) begin
          mem_re = 1'b1;
          if (mem_ready) nxt = S_WB;
        end else if (is_sw) begin
          mem_we = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end
        end else begin
          nxt = S_FETCH;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        retire     = 1'b1;
        nxt        = S_FETCH;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control sequencer for the MIPS-subset datapath. It moves each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every datapath select and write strobe, and chooses the immediate-extension mode (sign, zero or upper) used by the immediate extender. It handshakes with a variable-latency memory port and counts retired instructions. It sits between the instruction register (opcode/funct inputs) and the datapath muxes and register files.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; held stable by the datapath after FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_re, mem_we  out  1  memory read and write strobes
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR, and MDR, from memory
- pc_we  out  1  PC write enable
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B input: 00 = rt, 01 = constant 4, 10 = ext(imm), 11 = ext(imm)<<2
- ext_op  out  2  extension mode: 00 = sign, 01 = zero, 10 = imm<<16
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 PASS_B
- reg_we, reg_dst, mem_to_reg  out  1  register write; reg_dst 1 = rd, 0 = rt; mem_to_reg 1 = MDR
- illegal  out  1  one-cycle pulse on an unsupported instruction
- retired  out  CNT_W  count of completed instructions
- state  out  3  current state (debug)

## Operation
- States and encodings: IDLE = 7, FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4.
- Supported instructions:
  - R-type (opcode 0x00) with funct 0x21 addu→ADD, 0x23 subu→SUB, 0x24→AND, 0x25→OR, 0x2A→SLT.
  - addiu 0x09 (sign), andi 0x0C (zero), ori 0x0D (zero), lui 0x0F (upper, PASS_B).
  - lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Every other opcode, and R-type with any other funct, is illegal.
- Outputs not listed for a state are 0. All outputs are decoded combinationally from the state register plus opcode/funct/zero/mem_ready.
- IDLE: all outputs 0. Goes to FETCH unconditionally.
- FETCH:
  - mem_re = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD, pc_src = 00.
  - When mem_ready = 1: ir_we = 1, pc_we = 1, go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a = 0, alu_src_b = 11, ext_op = 00, alu_op = ADD (branch target into ALUOut).
  - j: pc_we = 1, pc_src = 10, retire, go to FETCH.
  - illegal: illegal = 1, go to FETCH, no retire.
  - All others: go to EXEC.
- EXEC:
  - R-type: alu_src_a = 1, alu_src_b = 00, alu_op per funct, go to WB.
  - I-arith: alu_src_a = 1, alu_src_b = 10, ext_op and alu_op per opcode, go to WB.
  - lw/sw: alu_src_a = 1, alu_src_b = 10, ext_op = 00, ADD, go to MEM.
  - beq: alu_src_a = 1, alu_src_b = 00, SUB, pc_src = 01, pc_we = zero; retire, go to FETCH.
- MEM: iord = 1.
  - lw: mem_re = 1; when mem_ready = 1, ir_we stays 0 (the datapath's MDR loads on mem_read with iord = 1), go to WB.
  - sw: mem_we = 1; when mem_ready = 1, retire, go to FETCH.
  - While mem_ready = 0: hold the state and all strobes.
- WB: reg_we = 1.
  - reg_dst = 1 for R-type, else 0; mem_to_reg = 1 for lw.
  - Retire, go to FETCH.
- retired increments by 1 on each retiring transition and wraps modulo 2^CNT_W.

## Timing
- Asynchronous reset (rst_n low): state = IDLE, retired = 0, so every strobe is 0 immediately, including one asserted mid-access. The first FETCH is in the 2nd rising edge after rst_n deasserts.
- Cycle counts with mem_ready = 1 throughout: j 2, beq 3, sw 4, R/I-arith 4, lw 5, illegal 2. Each cycle with mem_ready = 0 in FETCH or MEM adds one cycle.
- mem_re and mem_we are held continuously until the cycle in which mem_ready = 1. They are never both high.
- illegal and every write strobe last exactly one cycle per occurrence, except strobes that are held during a memory wait.
- retired updates on the clock edge that leaves the retiring state; it is visible the following cycle.

## Test plan
- Reset mid-access: sw in MEM with mem_ready = 0, pull rst_n low → mem_we drops to 0 without a clock edge, state = 7, retired = 0. After release, state goes 7→0.
- addiu (0x09) with mem_ready = 1 → states 0,1,2,4. EXEC shows alu_src_b = 10, ext_op = 00, alu_op = 0. WB shows reg_we = 1, reg_dst = 0. retired goes 0→1 after 4 cycles.
- ori (0x0D) and lui (0x0F) → EXEC ext_op = 01 with alu_op = 3, and ext_op = 10 with alu_op = 5, respectively.
- lw with mem_ready low for 3 cycles in MEM → MEM lasts 4 cycles with mem_re = 1 and iord = 1 held. Total 8 cycles; WB shows mem_to_reg = 1.
- beq with zero = 1 → pc_we = 1 and pc_src = 01 in EXEC. With zero = 0 → pc_we = 0. Both take 3 cycles and both retire.
- Opcode 0x3F, and R-type funct 0x00 → illegal = 1 for one cycle in DECODE, back to FETCH, retired unchanged.
